// File: rtl/fifo_width_down_if.sv
// fifo_width_down_if: write/read handshake bundle for the width-down FIFO.
// Rev 1.0
`default_nettype none

interface fifo_width_down_if #(
  parameter int OUT_WIDTH  = 8,
  parameter int RATIO      = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                          i_flush;
  logic                          i_wr;
  logic [OUT_WIDTH*RATIO-1:0]    i_wr_data;
  logic                          i_rd;
  logic [OUT_WIDTH-1:0]          o_rd_data;
  logic                          o_last_slice;
  logic                          o_empty;
  logic                          o_full;
  logic [ADDR_WIDTH:0]           o_word_count;
  logic                          o_overflow;
  logic                          o_underflow;

  modport master (
    output i_flush, i_wr, i_wr_data, i_rd,
    input  o_rd_data, o_last_slice, o_empty, o_full, o_word_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_wr, i_wr_data, i_rd,
    output o_rd_data, o_last_slice, o_empty, o_full, o_word_count, o_overflow, o_underflow
  );
endinterface

`default_nettype wire

// File: rtl/fifo_slice_mux.sv
// fifo_slice_mux: selects one OUT_WIDTH slice of a RATIO-slice word, LSB- or MSB-first.
// Rev 1.0
`default_nettype none

module fifo_slice_mux #(
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0
) (
  input  wire logic [OUT_WIDTH*RATIO-1:0]                         word,
  input  wire logic [(($clog2(RATIO) > 1) ? $clog2(RATIO) : 1)-1:0] sel,
  output logic      [OUT_WIDTH-1:0]                               slice
);
  localparam int SLICE_W = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1;

  // Compare against each legal index so an unused code (non-power-of-two RATIO) yields zero.
  always_comb begin
    slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel == SLICE_W'(i)) begin
        slice = word[((MSB_FIRST != 0) ? (RATIO - 1 - i) : i) * OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/fifo_width_down.sv
// fifo_width_down: stores wide words, emits them as RATIO narrow first-word-fall-through slices.
// Rev 1.0
`default_nettype none

module fifo_width_down #(
  parameter int OUT_WIDTH  = 8,
  parameter int RATIO      = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int MSB_FIRST  = 0
) (
  input wire logic         i_clk,
  input wire logic         i_reset,
  fifo_width_down_if.slave bus
);
  localparam int IN_WIDTH = OUT_WIDTH * RATIO;
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int SLICE_W  = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [SLICE_W-1:0]  LAST_IDX   = SLICE_W'(RATIO - 1);

  logic [IN_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [SLICE_W-1:0]    slice_cnt;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  word_done;
  logic [OUT_WIDTH-1:0]  head_slice;

  assign wr_acc    = bus.i_wr && !full;
  assign rd_acc    = bus.i_rd && !empty;
  assign word_done = rd_acc && (slice_cnt == LAST_IDX);

  always_comb begin
    count_next = count;
    if (wr_acc && !word_done) begin
      count_next = count + CNT_ONE;
    end else if (!wr_acc && word_done) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      slice_cnt <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.i_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      slice_cnt <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        // Explicit wrap at RATIO-1 so non-power-of-two ratios work.
        if (slice_cnt == LAST_IDX) begin
          slice_cnt <= '0;
          rd_ptr    <= rd_ptr + 1'b1;
        end else begin
          slice_cnt <= slice_cnt + 1'b1;
        end
      end
      count     <= count_next;
      empty     <= (count_next == '0);
      full      <= (count_next == FULL_COUNT);
      overflow  <= bus.i_wr && full;
      underflow <= bus.i_rd && empty;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !bus.i_flush) begin
      mem[wr_ptr] <= bus.i_wr_data;
    end
  end

  fifo_slice_mux #(
    .OUT_WIDTH (OUT_WIDTH),
    .RATIO     (RATIO),
    .MSB_FIRST (MSB_FIRST)
  ) u_slice_mux (
    .word  (mem[rd_ptr]),
    .sel   (slice_cnt),
    .slice (head_slice)
  );

  assign bus.o_rd_data    = head_slice;
  assign bus.o_last_slice = !empty && (slice_cnt == LAST_IDX);
  assign bus.o_empty      = empty;
  assign bus.o_full       = full;
  assign bus.o_word_count = count;
  assign bus.o_overflow   = overflow;
  assign bus.o_underflow  = underflow;
endmodule

`default_nettype wire

// File: tb/tb_fifo_width_down.sv
// tb_fifo_width_down: directed scenarios on three configurations plus a queue-model random run.
// Rev 1.0
`default_nettype none

module tb_fifo_width_down;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  // b0: defaults; b1: MSB-first, depth 4; b2: RATIO=3, depth 4
  fifo_width_down_if #(.OUT_WIDTH(8), .RATIO(4), .ADDR_WIDTH(4)) b0 ();
  fifo_width_down_if #(.OUT_WIDTH(8), .RATIO(4), .ADDR_WIDTH(2)) b1 ();
  fifo_width_down_if #(.OUT_WIDTH(8), .RATIO(3), .ADDR_WIDTH(2)) b2 ();

  fifo_width_down #(.OUT_WIDTH(8), .RATIO(4), .ADDR_WIDTH(4), .MSB_FIRST(0))
    u0 (.i_clk(clk), .i_reset(rst), .bus(b0));
  fifo_width_down #(.OUT_WIDTH(8), .RATIO(4), .ADDR_WIDTH(2), .MSB_FIRST(1))
    u1 (.i_clk(clk), .i_reset(rst), .bus(b1));
  fifo_width_down #(.OUT_WIDTH(8), .RATIO(3), .ADDR_WIDTH(2), .MSB_FIRST(0))
    u2 (.i_clk(clk), .i_reset(rst), .bus(b2));

  task automatic d0_cycle(input bit wr, input logic [31:0] d, input bit rd, input bit fl);
    b0.i_wr = wr; b0.i_wr_data = d; b0.i_rd = rd; b0.i_flush = fl;
    @(posedge clk); #1;
    b0.i_wr = 0; b0.i_rd = 0; b0.i_flush = 0;
  endtask

  task automatic d1_cycle(input bit wr, input logic [31:0] d, input bit rd);
    b1.i_wr = wr; b1.i_wr_data = d; b1.i_rd = rd; b1.i_flush = 0;
    @(posedge clk); #1;
    b1.i_wr = 0; b1.i_rd = 0;
  endtask

  task automatic d2_cycle(input bit wr, input logic [23:0] d, input bit rd);
    b2.i_wr = wr; b2.i_wr_data = d; b2.i_rd = rd; b2.i_flush = 0;
    @(posedge clk); #1;
    b2.i_wr = 0; b2.i_rd = 0;
  endtask

  task automatic test_reset;
    total++; if (b0.o_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", b0.o_empty); else passed++;
    total++; if (b0.o_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", b0.o_full); else passed++;
    total++; if (b0.o_word_count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", b0.o_word_count); else passed++;
    total++; if (b0.o_last_slice !== 1'b0) $display("FAIL reset_last got=%b exp=0", b0.o_last_slice); else passed++;
    total++; if ({b0.o_overflow, b0.o_underflow} !== 2'b00)
      $display("FAIL reset_pulses got=%b exp=00", {b0.o_overflow, b0.o_underflow}); else passed++;
    total++; if (b1.o_empty !== 1'b1) $display("FAIL reset_empty_b1 got=%b exp=1", b1.o_empty); else passed++;
  endtask

  task automatic test_order;
    logic [7:0] exp [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    d0_cycle(1, 32'hDDCCBBAA, 0, 0);
    d0_cycle(1, 32'h44332211, 0, 0);
    total++; if (b0.o_word_count !== 5'd2) $display("FAIL order_count got=%0d exp=2", b0.o_word_count); else passed++;
    for (int k = 0; k < 8; k++) begin
      total++; if (b0.o_rd_data !== exp[k]) $display("FAIL order_data[%0d] got=%h exp=%h", k, b0.o_rd_data, exp[k]); else passed++;
      total++; if (b0.o_last_slice !== (k % 4 == 3)) $display("FAIL order_last[%0d] got=%b exp=%b", k, b0.o_last_slice, (k % 4 == 3)); else passed++;
      d0_cycle(0, 0, 1, 0);
    end
    total++; if (b0.o_empty !== 1'b1) $display("FAIL order_empty got=%b exp=1", b0.o_empty); else passed++;
  endtask

  task automatic test_underflow_flush;
    d0_cycle(0, 0, 1, 0);
    total++; if (b0.o_underflow !== 1'b1) $display("FAIL underflow_pulse got=%b exp=1", b0.o_underflow); else passed++;
    total++; if (b0.o_word_count !== 5'd0 || b0.o_empty !== 1'b1)
      $display("FAIL underflow_state got count=%0d empty=%b exp 0/1", b0.o_word_count, b0.o_empty); else passed++;
    d0_cycle(0, 0, 0, 0);
    total++; if (b0.o_underflow !== 1'b0) $display("FAIL underflow_once got=%b exp=0", b0.o_underflow); else passed++;
    d0_cycle(1, 32'h01020304, 0, 0);
    d0_cycle(1, 32'h05060708, 0, 0);
    d0_cycle(1, 32'h090A0B0C, 0, 0);
    d0_cycle(0, 0, 1, 0);
    d0_cycle(0, 0, 1, 0);
    total++; if (b0.o_rd_data !== 8'h02) $display("FAIL flush_pre_data got=%h exp=02", b0.o_rd_data); else passed++;
    d0_cycle(1, 32'hEEEEEEEE, 1, 1);
    total++; if (b0.o_empty !== 1'b1 || b0.o_word_count !== 5'd0)
      $display("FAIL flush_state got empty=%b count=%0d exp 1/0", b0.o_empty, b0.o_word_count); else passed++;
    total++; if ({b0.o_overflow, b0.o_underflow, b0.o_last_slice} !== 3'b000)
      $display("FAIL flush_flags got=%b exp=000", {b0.o_overflow, b0.o_underflow, b0.o_last_slice}); else passed++;
    d0_cycle(1, 32'h0A0B0C0D, 0, 0);
    total++; if (b0.o_rd_data !== 8'h0D || b0.o_word_count !== 5'd1)
      $display("FAIL flush_next got data=%h count=%0d exp 0d/1", b0.o_rd_data, b0.o_word_count); else passed++;
  endtask

  task automatic test_async_reset;
    d0_cycle(0, 0, 1, 0);
    total++; if (b0.o_rd_data !== 8'h0C) $display("FAIL async_pre_data got=%h exp=0c", b0.o_rd_data); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (b0.o_empty !== 1'b1 || b0.o_word_count !== 5'd0 || b0.o_last_slice !== 1'b0)
      $display("FAIL async_reset got empty=%b count=%0d last=%b exp 1/0/0", b0.o_empty, b0.o_word_count, b0.o_last_slice); else passed++;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first;
    logic [7:0] exp [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    d1_cycle(1, 32'hDDCCBBAA, 0);
    for (int k = 0; k < 4; k++) begin
      total++; if (b1.o_rd_data !== exp[k]) $display("FAIL msb_data[%0d] got=%h exp=%h", k, b1.o_rd_data, exp[k]); else passed++;
      d1_cycle(0, 0, 1);
    end
    total++; if (b1.o_empty !== 1'b1) $display("FAIL msb_empty got=%b exp=1", b1.o_empty); else passed++;
  endtask

  task automatic test_full;
    for (int k = 0; k < 4; k++) d1_cycle(1, 32'h10 + k, 0);
    total++; if (b1.o_full !== 1'b1 || b1.o_word_count !== 3'd4)
      $display("FAIL full_set got full=%b count=%0d exp 1/4", b1.o_full, b1.o_word_count); else passed++;
    d1_cycle(1, 32'hFFFFFFFF, 0);
    total++; if (b1.o_overflow !== 1'b1 || b1.o_word_count !== 3'd4)
      $display("FAIL full_overflow got ovf=%b count=%0d exp 1/4", b1.o_overflow, b1.o_word_count); else passed++;
    d1_cycle(0, 0, 0);
    total++; if (b1.o_overflow !== 1'b0) $display("FAIL full_ovf_once got=%b exp=0", b1.o_overflow); else passed++;
    for (int k = 0; k < 3; k++) d1_cycle(0, 0, 1);
    total++; if (b1.o_full !== 1'b1) $display("FAIL full_partial got=%b exp=1", b1.o_full); else passed++;
    d1_cycle(0, 0, 1);
    total++; if (b1.o_full !== 1'b0 || b1.o_word_count !== 3'd3)
      $display("FAIL full_release got full=%b count=%0d exp 0/3", b1.o_full, b1.o_word_count); else passed++;
  endtask

  task automatic test_simultaneous;
    for (int k = 0; k < 4; k++) d1_cycle(0, 0, 1);
    for (int k = 0; k < 3; k++) d1_cycle(0, 0, 1);
    d1_cycle(1, 32'h20, 1);
    total++; if (b1.o_word_count !== 3'd2 || b1.o_overflow !== 1'b0)
      $display("FAIL simul_mid got count=%0d ovf=%b exp 2/0", b1.o_word_count, b1.o_overflow); else passed++;
    d1_cycle(1, 32'h21, 0);
    d1_cycle(1, 32'h22, 0);
    for (int k = 0; k < 3; k++) d1_cycle(0, 0, 1);
    d1_cycle(1, 32'h23, 1);
    total++; if (b1.o_word_count !== 3'd3 || b1.o_overflow !== 1'b1 || b1.o_full !== 1'b0)
      $display("FAIL simul_full got count=%0d ovf=%b full=%b exp 3/1/0", b1.o_word_count, b1.o_overflow, b1.o_full); else passed++;
  endtask

  task automatic test_ratio3;
    logic [7:0] exp [3] = '{8'hAA, 8'hBB, 8'hCC};
    d2_cycle(1, 24'hCCBBAA, 0);
    for (int k = 0; k < 3; k++) begin
      total++; if (b2.o_rd_data !== exp[k] || b2.o_last_slice !== (k == 2))
        $display("FAIL r3_slice[%0d] got=%h/%b exp=%h/%b", k, b2.o_rd_data, b2.o_last_slice, exp[k], (k == 2)); else passed++;
      d2_cycle(0, 0, 1);
    end
    total++; if (b2.o_empty !== 1'b1) $display("FAIL r3_empty got=%b exp=1", b2.o_empty); else passed++;
    d2_cycle(1, 24'h332211, 0);
    total++; if (b2.o_rd_data !== 8'h11 || b2.o_last_slice !== 1'b0)
      $display("FAIL r3_wrap got=%h/%b exp=11/0", b2.o_rd_data, b2.o_last_slice); else passed++;
  endtask

  task automatic test_random;
    logic [31:0] q [$];
    logic [31:0] head;
    int          sl = 0;
    bit          wr, rd, was_full, was_empty;
    logic [31:0] d;
    for (int n = 0; n < 600; n++) begin
      wr = (n < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 1);
      rd = (n < 300) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 9);
      d  = $urandom;
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      if (rd && !was_empty) begin
        sl++;
        if (sl == 4) begin
          void'(q.pop_front());
          sl = 0;
        end
      end
      if (wr && !was_full) q.push_back(d);
      d0_cycle(wr, d, rd, 0);
      total++; if (b0.o_word_count !== 5'(q.size()))
        $display("FAIL rnd_count@%0d got=%0d exp=%0d", n, b0.o_word_count, q.size()); else passed++;
      total++; if (b0.o_full !== (q.size() == 16) || b0.o_empty !== (q.size() == 0))
        $display("FAIL rnd_flags@%0d got full=%b empty=%b exp %b/%b", n, b0.o_full, b0.o_empty, (q.size() == 16), (q.size() == 0)); else passed++;
      total++; if (b0.o_overflow !== (wr && was_full) || b0.o_underflow !== (rd && was_empty))
        $display("FAIL rnd_pulses@%0d got ovf=%b unf=%b exp %b/%b", n, b0.o_overflow, b0.o_underflow, (wr && was_full), (rd && was_empty)); else passed++;
      total++; if (b0.o_last_slice !== (q.size() != 0 && sl == 3))
        $display("FAIL rnd_last@%0d got=%b exp=%b", n, b0.o_last_slice, (q.size() != 0 && sl == 3)); else passed++;
      if (q.size() != 0) begin
        head = q[0];
        total++; if (b0.o_rd_data !== head[sl*8 +: 8])
          $display("FAIL rnd_data@%0d got=%h exp=%h", n, b0.o_rd_data, head[sl*8 +: 8]); else passed++;
      end
    end
  endtask

  initial begin
    b0.i_wr = 0; b0.i_rd = 0; b0.i_flush = 0; b0.i_wr_data = '0;
    b1.i_wr = 0; b1.i_rd = 0; b1.i_flush = 0; b1.i_wr_data = '0;
    b2.i_wr = 0; b2.i_rd = 0; b2.i_flush = 0; b2.i_wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_order;
    test_underflow_flush;
    test_async_reset;
    test_msb_first;
    test_full;
    test_simultaneous;
    test_ratio3;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fifo_width_down.md
Name: fifo_width_down

Overview:
- Parametrised successor to the debug-path 32-to-8 transmit FIFO: stores wide words and emits them as RATIO narrow slices, one slice per read.
- Sits between the debug/register-dump producer (wide writes) and the UART transmitter (byte reads).
- Adds over the previous generation:
  - generic width ratio and depth;
  - selectable slice order;
  - occupancy count;
  - synchronous flush;
  - overflow/underflow pulses;
  - full/empty derived from an explicit word count, so the slice counter never corrupts the full flag.

Parameters:
OUT_WIDTH, 8, width of one read slice in bits
RATIO, 4, slices per written word (>=2); IN_WIDTH = OUT_WIDTH*RATIO
ADDR_WIDTH, 4, log2 of FIFO depth in words; DEPTH = 2**ADDR_WIDTH
MSB_FIRST, 0, 0: slice 0 = bits [OUT_WIDTH-1:0] (little-endian, matches current UART dump); 1: slice 0 = top OUT_WIDTH bits

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_flush  in  1  synchronous clear of pointers, slice counter and count
i_wr  in  1  write request, one wide word
i_wr_data  in  OUT_WIDTH*RATIO  word to store
i_rd  in  1  read request, consumes one slice
o_rd_data  out  OUT_WIDTH  current head slice (first-word-fall-through)
o_last_slice  out  1  high when o_rd_data is the final slice of the head word
o_empty  out  1  no word (full or partial) held
o_full  out  1  DEPTH words held
o_word_count  out  ADDR_WIDTH+1  words held, including the partially read head word
o_overflow  out  1  1-cycle pulse: i_wr while o_full (write dropped)
o_underflow  out  1  1-cycle pulse: i_rd while o_empty (read ignored)

Behaviour:
- Reset (async assert, any cycle, including mid-word):
  - wr_ptr=0, rd_ptr=0, slice_cnt=0, count=0;
  - o_empty=1, o_full=0, o_word_count=0, o_overflow=0, o_underflow=0, o_last_slice=0.
  - Memory contents are not cleared. o_rd_data is don't-care while o_empty=1.
- Flush: i_flush=1 gives the reset state on the next edge. It has priority over i_wr and i_rd in the same cycle, and produces no overflow/underflow pulse.
- Write accepted iff i_wr && !o_full:
  - mem[wr_ptr] <= i_wr_data; wr_ptr wraps modulo DEPTH.
  - Data is visible on o_rd_data the cycle after acceptance if the FIFO was empty.
- Read accepted iff i_rd && !o_empty:
  - If slice_cnt < RATIO-1: slice_cnt+1.
  - Else: slice_cnt=0, rd_ptr+1 (wraps), word slot freed.
- Count update per edge: count + wr_acc - word_done, where word_done = read accepted on the last slice.
  - o_full = (count==DEPTH); o_empty = (count==0). Both are registered and consistent with count.
  - A partially read head word still occupies its slot.
- Simultaneous events:
  - Write while full is rejected even if the same cycle completes a word read. The slot frees next cycle; overflow pulses.
  - Write and read when count==0: the write is accepted, the read is ignored and underflow pulses.
  - Write + last-slice read at 0<count<DEPTH: count unchanged.
- Slice select:
  - MSB_FIRST=0: o_rd_data = mem[rd_ptr][slice_cnt*OUT_WIDTH +: OUT_WIDTH].
  - MSB_FIRST=1: index (RATIO-1-slice_cnt).
  - Purely combinational from registered rd_ptr/slice_cnt; zero read latency.
- o_last_slice = !o_empty && slice_cnt==RATIO-1.
- slice_cnt width = max(1, clog2(RATIO)); RATIO need not be a power of two (count wraps at RATIO-1, not at counter overflow).

Decomposition:
- No shared package. Localparams in-module: IN_WIDTH, DEPTH, SLICE_W = max(1,clog2(RATIO)).
- One natural sub-module: fifo_slice_mux. Parameters OUT_WIDTH, RATIO, MSB_FIRST; takes the word and slice index, returns the slice. It is reusable by the planned width-up receive FIFO.

Test Plan:
- Reset/order, defaults: write 0xDDCCBBAA then 0x44332211 -> 8 reads yield AA,BB,CC,DD,11,22,33,44; o_last_slice high on DD and 44; o_empty=1 after the 8th read.
- MSB_FIRST=1: write 0xDDCCBBAA -> reads give DD,CC,BB,AA.
- Full boundary, ADDR_WIDTH=2: write 4 words -> o_full=1, o_word_count=4. Fifth write -> dropped, o_overflow pulses once. Read 3 slices -> still full. 4th slice -> o_full=0, count=3.
- Simultaneous: at count=2, write + last-slice read same cycle -> count stays 2. At count=4, same -> write dropped, count=3.
- Underflow and flush: read when empty -> o_underflow pulse, state unchanged. With 3 words and slice_cnt=2, i_flush+i_wr -> empty, count=0, next write's slice 0 appears.
- Async reset mid-word: assert i_reset between clock edges after 1 of 4 slices read -> outputs reach reset values immediately, without waiting for an edge.
- Non-power-of-two: RATIO=3, OUT_WIDTH=8 -> word 0xCCBBAA reads AA,BB,CC, then slice_cnt returns to 0.
